demux1x4_buf: RTL and testbench

Registered 1-to-4 demultiplexer: the distribution counterpart to the 4-to-1 select mux. It takes one valid/ready source stream carrying a 2-bit destination select and delivers each word to one of four sink channels. Every channel has a one-entry output buffer, so each accepted word appears on its selected sink exactly one cycle later. It sits between a single producer (e.g. a store/write-back path) and up to four independent consumers (MMIO peripherals, debug taps), and counts delivered words per channel.

---
 rtl/demux_pkg.sv | 31 +++
 rtl/demux_slot.sv | 53 +++++
 rtl/demux1x4_buf.sv | 65 ++++++
 tb/tb_demux1x4_buf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer: channel count,
// select encoding, buffer state type and the select decoder.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'b00;
    localparam logic [SEL_W-1:0] CH1 = 2'b01;
    localparam logic [SEL_W-1:0] CH2 = 2'b10;
    localparam logic [SEL_W-1:0] CH3 = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        case (sel)
            CH0:     oh = 4'b0001;
            CH1:     oh = 4'b0010;
            CH2:     oh = 4'b0100;
            CH3:     oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry buffer with its own valid/ready sink side
// and a wrapping count of delivered words.
module demux_slot
    import demux_pkg::*;
#(
    parameter int n     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [n-1:0]     load_data,
    input  logic             ready,
    output logic             valid,
    output logic [n-1:0]     data,
    output logic [CNT_W-1:0] cnt
);

    buf_state_e       state_q, state_d;
    logic [n-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deliver;

    // A load wins over a drain so a same-cycle deliver+reload keeps the slot FULL.
    always_comb begin
        deliver = (state_q == FULL) && ready;
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (deliver) begin
            state_d = EMPTY;
        end
        data_d = load ? load_data : data_q;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, deliver};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = (state_q == FULL);
    assign data  = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux1x4_buf.sv
// Registered 1-to-4 demultiplexer: routes each accepted source word into the
// one-entry buffer of the channel named by in_sel, one cycle of latency.
module demux1x4_buf
    import demux_pkg::*;
#(
    parameter int n     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [n-1:0]     in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [n-1:0]     out_data0,
    output logic [n-1:0]     out_data1,
    output logic [n-1:0]     out_data2,
    output logic [n-1:0]     out_data3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic [NUM_CH-1:0] load_vec;
    logic              accept;
    logic [n-1:0]      data_arr [NUM_CH];
    logic [CNT_W-1:0]  cnt_arr  [NUM_CH];

    // Readiness looks only at the addressed channel, so a stalled sink blocks
    // the source just while it is being targeted.
    always_comb begin
        in_ready = !out_valid[in_sel] || out_ready[in_sel];
        accept   = in_valid && in_ready;
        load_vec = accept ? sel_onehot(in_sel) : '0;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .n     (n),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (data_arr[k]),
            .cnt       (cnt_arr[k])
        );
    end

    assign out_data0 = data_arr[0];
    assign out_data1 = data_arr[1];
    assign out_data2 = data_arr[2];
    assign out_data3 = data_arr[3];
    assign cnt0      = cnt_arr[0];
    assign cnt1      = cnt_arr[1];
    assign cnt2      = cnt_arr[2];
    assign cnt3      = cnt_arr[3];

endmodule

// File: tb/tb_demux1x4_buf.sv
// Bench for demux1x4_buf: directed scenario tasks plus a per-channel scoreboard
// that records accepted words and checks them at each sink handshake.
module tb_demux1x4_buf;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_sel;
    logic [N-1:0]  in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [N-1:0]  out_data0, out_data1, out_data2, out_data3;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

    logic [N-1:0]  od [4];
    logic [CW-1:0] cn [4];
    logic [N-1:0]  sbq [4][$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;
    assign cn[0] = cnt0;
    assign cn[1] = cnt1;
    assign cn[2] = cnt2;
    assign cn[3] = cnt3;

    demux1x4_buf #(.n(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    // Scoreboard: sample on the falling edge, pop on sink handshakes before
    // pushing the source word so a same-cycle reload is ordered correctly.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    n_cmp++;
                    if (sbq[k].size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected_ch%0d: got data %h, expected no word", k, od[k]);
                    end else begin
                        logic [N-1:0] exp_w;
                        exp_w = sbq[k].pop_front();
                        if (od[k] !== exp_w) begin
                            n_bad++;
                            $display("FAIL sb_data_ch%0d: got %h, expected %h", k, od[k], exp_w);
                        end
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sbq[in_sel].push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
        #2;
        n_cmp++;
        if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_init_valid: got %b, expected 0000", out_valid); end
        tick(); tick();
        rst = 1'b0;
        // Fill channels 1 and 3 with their sinks stalled.
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11; tick();
        in_sel = 2'd3; in_data = 8'h33; tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 4'b1010) begin n_bad++; $display("FAIL reset_prefill_valid: got %b, expected 1010", out_valid); end
        n_cmp++;
        if (out_data1 !== 8'h11 || out_data3 !== 8'h33) begin
            n_bad++; $display("FAIL reset_prefill_data: got %h/%h, expected 11/33", out_data1, out_data3);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_async_valid: got %b, expected 0000", out_valid); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (od[k] !== '0 || cn[k] !== '0) begin
                n_bad++; $display("FAIL reset_async_ch%0d: got data %h cnt %0d, expected 0/0", k, od[k], cn[k]);
            end
        end
        for (int s = 0; s < 4; s++) begin
            in_sel = s[1:0];
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_sel%0d: got %b, expected 1", s, in_ready); end
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_routing();
        do_reset();
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = k[1:0]; in_data = 8'hA0 + 8'(k);
            tick();
            n_cmp++;
            if (out_valid !== (4'b0001 << k) || od[k] !== 8'hA0 + 8'(k)) begin
                n_bad++;
                $display("FAIL route_ch%0d: got valid %b data %h, expected %b/%h", k, out_valid, od[k], 4'b0001 << k, 8'hA0 + 8'(k));
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL route_drained: got %b, expected 0000", out_valid); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cn[k] !== 4'd1) begin n_bad++; $display("FAIL route_cnt%0d: got %0d, expected 1", k, cn[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h55;
        tick();
        in_data = 8'h66;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_sel2: got %b, expected 0", in_ready); end
        in_valid = 1'b0; in_sel = 2'd0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_sel0: got %b, expected 1", in_ready); end
        in_valid = 1'b1; in_sel = 2'd2;
        tick(); tick();
        n_cmp++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 8'h55) begin
            n_bad++; $display("FAIL bp_hold: got valid %b data %h, expected 1/55", out_valid[2], out_data2);
        end
        out_ready[2] = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %b, expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 8'h66 || cnt2 !== 4'd1) begin
            n_bad++; $display("FAIL bp_reload: got valid %b data %h cnt %0d, expected 1/66/1", out_valid[2], out_data2, cnt2);
        end
        tick();
        n_cmp++;
        if (out_valid[2] !== 1'b0 || cnt2 !== 4'd2) begin
            n_bad++; $display("FAIL bp_drain: got valid %b cnt %0d, expected 0/2", out_valid[2], cnt2);
        end
    endtask

    task automatic test_independence();
        do_reset();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
        tick();
        out_ready = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            in_sel = 2'd0; in_data = 8'h10 + 8'(i);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL indep_ready_%0d: got %b, expected 1", i, in_ready); end
            tick();
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data0 !== 8'h10 + 8'(i)) begin
                n_bad++; $display("FAIL indep_word_%0d: got valid %b data %h, expected 1/%h", i, out_valid[0], out_data0, 8'h10 + 8'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (cnt0 !== 4'd8 || cnt1 !== 4'd0) begin
            n_bad++; $display("FAIL indep_cnt: got cnt0 %0d cnt1 %0d, expected 8/0", cnt0, cnt1);
        end
        n_cmp++;
        if (out_valid !== 4'b0010 || out_data1 !== 8'h77) begin
            n_bad++; $display("FAIL indep_ch1_held: got valid %b data1 %h, expected 0010/77", out_valid, out_data1);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 4'b1000;
        in_valid = 1'b1; in_sel = 2'd3;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(8'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (cnt3 !== 4'd1 || out_valid[3] !== 1'b0) begin
            n_bad++; $display("FAIL wrap_cnt3: got cnt %0d valid %b, expected 1/0", cnt3, out_valid[3]);
        end
    endtask

    task automatic test_idle();
        do_reset();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hC3; tick();
        in_sel = 2'd2; in_data = 8'h5A; tick();
        in_valid = 1'b0; in_sel = 'x; in_data = 'x;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 4'b0101 || out_data0 !== 8'hC3 || out_data2 !== 8'h5A ||
                out_data1 !== 8'h00 || out_data3 !== 8'h00) begin
                n_bad++;
                $display("FAIL idle_state_%0d: got valid %b data %h/%h/%h/%h, expected 0101/c3/00/5a/00",
                         c, out_valid, out_data0, out_data1, out_data2, out_data3);
            end
            n_cmp++;
            if ({cnt0, cnt1, cnt2, cnt3} !== '0) begin
                n_bad++; $display("FAIL idle_cnt_%0d: got %h, expected 0", c, {cnt0, cnt1, cnt2, cnt3});
            end
        end
        in_sel = 2'd0; in_data = '0;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_counter_wrap();
        test_idle();
        do_reset();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
